// File: rtl/pwm_duty_ctrl.sv
// Compare-register generator for the PWM stage: converts a duty/phase request
// into cr1/cr2, ramping the width in bounded steps and publishing only at period boundaries.
module pwm_duty_ctrl #(
  parameter int unsigned PERIOD       = 5000,
  parameter int unsigned STEP         = 250,
  parameter int unsigned RAMP_PERIODS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [6:0]  duty_in,
  input  logic [15:0] phase_in,
  output logic [15:0] cr1,
  output logic [15:0] cr2,
  output logic        busy,
  output logic        period_tick,
  output logic        clamped,
  output logic [1:0]  fsm_state
);

  localparam logic [15:0] LAST   = 16'(PERIOD - 1);
  localparam logic [15:0] PER16  = 16'(PERIOD);
  localparam logic [15:0] STEP16 = 16'(STEP);
  localparam logic [16:0] UNIT17 = 17'(PERIOD / 100);
  localparam int          RW     = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RW-1:0] RLAST = RW'(RAMP_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   pcnt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic [15:0]   target, target_nxt, target_new;
  logic [15:0]   width, width_nxt, width_step;
  logic [15:0]   phase;
  logic [6:0]    duty_c;
  logic [16:0]   prod;
  logic [15:0]   gap, amt;
  logic [15:0]   room, sh_cr1, sh_cr2;

  assign period_tick = (pcnt == LAST);
  assign fsm_state   = state;

  // load is a single-cycle strobe with no back-pressure: it is always accepted,
  // and the value present on the cycle load is high is the one latched.
  always_comb begin
    duty_c     = (duty_in > 7'd100) ? 7'd100 : duty_in;
    prod       = 17'(duty_c) * UNIT17;
    target_new = 16'(prod);
    target_nxt = load ? target_new : target;
  end

  always_comb begin
    if (target > width) begin
      gap        = target - width;
      amt        = (gap > STEP16) ? STEP16 : gap;
      width_step = width + amt;
    end else begin
      gap        = width - target;
      amt        = (gap > STEP16) ? STEP16 : gap;
      width_step = width - amt;
    end
  end

  // Shadow compare values: clip the start so the pulse never runs past the period end.
  always_comb begin
    room   = PER16 - width;
    sh_cr1 = (phase < room) ? phase : room;
    sh_cr2 = sh_cr1 + width;
  end

  always_comb begin
    state_nxt = state;
    width_nxt = width;
    rcnt_nxt  = rcnt;
    case (state)
      S_IDLE: begin
        if (load && (target_new != width)) begin
          state_nxt = S_WAIT;
          rcnt_nxt  = '0;
        end
      end
      S_WAIT: begin
        if (period_tick) begin
          if (rcnt == RLAST) begin
            state_nxt = S_STEP;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
      end
      S_STEP: begin
        // Step toward the old target; a same-cycle load decides where we go next.
        width_nxt = width_step;
        rcnt_nxt  = '0;
        state_nxt = (width_step == target_nxt) ? S_IDLE : S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pcnt    <= '0;
      rcnt    <= '0;
      target  <= '0;
      width   <= '0;
      phase   <= '0;
      cr1     <= '0;
      cr2     <= '0;
      busy    <= 1'b0;
      clamped <= 1'b0;
    end else begin
      state   <= state_nxt;
      width   <= width_nxt;
      rcnt    <= rcnt_nxt;
      target  <= target_nxt;
      pcnt    <= period_tick ? 16'd0 : pcnt + 16'd1;
      busy    <= (width_nxt != target_nxt);
      clamped <= load && (duty_in > 7'd100);
      if (load) phase <= phase_in;
      if (period_tick) begin
        cr1 <= sh_cr1;
        cr2 <= sh_cr2;
      end
    end
  end

endmodule
